// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package stage_fetch_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), presented in place of a faulted word
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // One decoded-side fetch entry
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
      logic        fault;
   } FetchEntry_t;

   // Address n words behind pc, modulo 2^32
   function automatic logic [31:0] pc_back(input logic [31:0] pc, input logic [1:0] n);
      return pc - {28'd0, n, 2'b00};
   endfunction

endpackage

// File: rtl/stage_fetch_buffer.sv
// Two-entry in-order fetch buffer; slot 0 is always the head.
module fetch_buffer
   import stage_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        push,
   input  FetchEntry_t push_entry,
   input  logic        pop,
   output FetchEntry_t head,
   output logic [1:0]  count
);

   FetchEntry_t [1:0] slot_q, slot_d;
   logic [1:0]        count_q, count_d;
   logic              do_pop;

   // Next slot contents and occupancy; flush discards everything but a same-cycle push
   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      do_pop  = pop && (count_q != 2'd0);
      if (flush) begin
         count_d = push ? 2'd1 : 2'd0;
         if (push) begin
            slot_d[0] = push_entry;
         end
      end else if (push && do_pop) begin
         if (count_q == 2'd1) begin
            slot_d[0] = push_entry;
         end else begin
            slot_d[0] = slot_q[1];
            slot_d[1] = push_entry;
         end
      end else if (push) begin
         if (count_q == 2'd0) begin
            slot_d[0] = push_entry;
         end else begin
            slot_d[1] = push_entry;
         end
         count_d = count_q + 2'd1;
      end else if (do_pop) begin
         slot_d[0] = slot_q[1];
         count_d   = count_q - 2'd1;
      end
   end

   // Storage and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= '0;
         count_q <= '0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
      end
   end

   assign head  = slot_q[0];
   assign count = count_q;

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: issues word fetches, tracks in-flight requests,
// drops stale responses after a redirect and buffers entries for decode.
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   output logic        o_IMemReq,
   output logic [31:0] o_IMemAddr,
   input  logic        i_IMemGrant,
   input  logic        i_IMemValid,
   input  logic [31:0] i_IMemData,
   input  logic        i_IMemError,
   input  logic        i_Stall,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectTarget,
   output logic        o_Valid,
   output logic [31:0] o_InstructionWord,
   output logic [31:0] o_PC,
   output logic        o_FetchFault
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  drop_q, drop_d;
   logic        halt_q, halt_d;
   logic        hold_q, hold_d;

   logic        cap_ok, grant, resp, resp_live;
   logic        buf_push, buf_pop, buf_flush;
   FetchEntry_t buf_in, buf_head;
   logic [1:0]  buf_count;

   // Request generation: a presented-but-ungranted request stays up even if halt arrives
   always_comb begin
      cap_ok     = (3'(out_q) + 3'(buf_count)) < 3'd2;
      o_IMemReq  = i_Reset_n && !i_Redirect && (hold_q || (cap_ok && !halt_q));
      o_IMemAddr = {pc_q[31:2], 2'b00};
      grant      = o_IMemReq && i_IMemGrant;
      resp       = i_IMemValid && (out_q != 2'd0);
      resp_live  = resp && (drop_q == 2'd0);
   end

   // Next-state and buffer control; redirect takes priority over everything else
   always_comb begin
      pc_d      = pc_q;
      out_d     = out_q + 2'(grant) - 2'(resp);
      drop_d    = drop_q;
      halt_d    = halt_q;
      hold_d    = o_IMemReq && !i_IMemGrant;
      buf_flush = 1'b0;
      buf_pop   = (buf_count != 2'd0) && !i_Stall;
      buf_push  = resp_live;
      // Live requests were issued back-to-back from the current PC, so the
      // oldest one sits out_q words behind it; no per-request PC queue needed.
      buf_in.pc    = pc_back(pc_q, out_q);
      buf_in.word  = i_IMemError ? NOP_WORD : i_IMemData;
      buf_in.fault = i_IMemError;
      if (grant) begin
         pc_d = pc_q + 32'd4;
      end
      if (resp && (drop_q != 2'd0)) begin
         drop_d = drop_q - 2'd1;
      end
      if (resp_live && i_IMemError) begin
         halt_d = 1'b1;
      end
      if (i_Redirect) begin
         pc_d         = i_RedirectTarget;
         buf_flush    = 1'b1;
         buf_pop      = 1'b0;
         drop_d       = out_q - 2'(resp);
         halt_d       = (i_RedirectTarget[1:0] != 2'b00);
         hold_d       = 1'b0;
         buf_push     = (i_RedirectTarget[1:0] != 2'b00);
         buf_in.pc    = i_RedirectTarget;
         buf_in.word  = NOP_WORD;
         buf_in.fault = 1'b1;
      end
   end

   // Fetch state registers
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pc_q   <= RESET_VECTOR;
         out_q  <= '0;
         drop_q <= '0;
         halt_q <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
         halt_q <= halt_d;
         hold_q <= hold_d;
      end
   end

   fetch_buffer u_fetch_buffer (
      .clk        (i_Clock),
      .rst_n      (i_Reset_n),
      .flush      (buf_flush),
      .push       (buf_push),
      .push_entry (buf_in),
      .pop        (buf_pop),
      .head       (buf_head),
      .count      (buf_count)
   );

   // Decode-facing outputs come straight from the buffer head
   always_comb begin
      o_Valid           = (buf_count != 2'd0);
      o_InstructionWord = buf_head.word;
      o_PC              = buf_head.pc;
      o_FetchFault      = buf_head.fault;
   end

endmodule

// File: tb/tb_stage_fetch.sv
// Randomized self-checking bench for stage_fetch with an in-order memory model
// and a transaction-level scoreboard of the expected instruction stream.
module tb_stage_fetch;

   localparam logic [31:0] RV     = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

   logic        i_Clock = 1'b0;
   logic        i_Reset_n = 1'b1;
   logic        o_IMemReq;
   logic [31:0] o_IMemAddr;
   logic        i_IMemGrant = 1'b0;
   logic        i_IMemValid = 1'b0;
   logic [31:0] i_IMemData = '0;
   logic        i_IMemError = 1'b0;
   logic        i_Stall = 1'b0;
   logic        i_Redirect = 1'b0;
   logic [31:0] i_RedirectTarget = '0;
   logic        o_Valid;
   logic [31:0] o_InstructionWord;
   logic [31:0] o_PC;
   logic        o_FetchFault;

   always #5 i_Clock = ~i_Clock;

   stage_fetch #(.RESET_VECTOR(RV)) dut (
      .i_Clock           (i_Clock),
      .i_Reset_n         (i_Reset_n),
      .o_IMemReq         (o_IMemReq),
      .o_IMemAddr        (o_IMemAddr),
      .i_IMemGrant       (i_IMemGrant),
      .i_IMemValid       (i_IMemValid),
      .i_IMemData        (i_IMemData),
      .i_IMemError       (i_IMemError),
      .i_Stall           (i_Stall),
      .i_Redirect        (i_Redirect),
      .i_RedirectTarget  (i_RedirectTarget),
      .o_Valid           (o_Valid),
      .o_InstructionWord (o_InstructionWord),
      .o_PC              (o_PC),
      .o_FetchFault      (o_FetchFault)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      bit          err;
      int unsigned rdy;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        fault;
   } ent_t;

   mreq_t       memq[$];
   ent_t        expq[$];
   logic [31:0] glog[$];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;
   int unsigned epoch = 0;
   int unsigned grant_pct = 100;
   int unsigned resp_pct = 100;
   int unsigned stall_pct = 0;
   logic [31:0] err_addr = NO_ERR;
   logic [31:0] exp_req_pc = RV;
   logic [31:0] err_pc = '0;
   logic [31:0] pend_addr = '0;
   bit          err_seen = 0;
   bit          mis_halt = 0;
   bit          req_pend = 0;
   bit          stray = 0;

   logic        s_req, s_valid, s_fault;
   logic [31:0] s_addr, s_pc, s_word;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   // One clock cycle: drive inputs at negedge, sample, check, advance model after posedge
   task automatic step(input bit redir, input logic [31:0] tgt, input bit stall);
      bit    rv;
      mreq_t h;
      ent_t  e;
      i_Redirect       = redir;
      i_RedirectTarget = redir ? tgt : $urandom;
      i_Stall          = stall;
      rv = (memq.size() > 0) && (memq[0].rdy <= cyc) && ($urandom_range(99) < resp_pct);
      if (rv) begin
         h           = memq[0];
         i_IMemValid = 1'b1;
         i_IMemData  = mem_word(h.addr);
         i_IMemError = h.err;
      end else begin
         i_IMemValid = stray;
         i_IMemData  = $urandom;
         i_IMemError = 1'($urandom_range(1));
      end
      stray = 0;
      #1;
      s_req   = o_IMemReq;
      s_addr  = o_IMemAddr;
      s_valid = o_Valid;
      s_pc    = o_PC;
      s_word  = o_InstructionWord;
      s_fault = o_FetchFault;
      i_IMemGrant = s_req && ($urandom_range(99) < grant_pct);
      if (redir) begin
         check_eq("req_on_redirect", 32'(s_req), 0);
      end else begin
         if (req_pend) begin
            check_eq("req_held", 32'(s_req), 1);
            check_eq("addr_held", s_addr, pend_addr);
         end
         if (mis_halt) check_eq("req_in_misaligned_halt", 32'(s_req), 0);
      end
      if (s_req) check_eq("addr_aligned", 32'(s_addr[1:0]), 0);
      if (i_IMemGrant) begin
         check_eq("grant_addr", s_addr, exp_req_pc);
         if (err_seen) check_eq("grant_after_error", s_addr, err_pc + 32'd4);
      end
      if (s_valid && !stall && !redir) begin
         if (expq.size() == 0) begin
            check_eq("pop_nothing_expected", 32'(s_valid), 0);
         end else begin
            e = expq.pop_front();
            check_eq("pop_pc", s_pc, e.pc);
            check_eq("pop_word", s_word, e.word);
            check_eq("pop_fault", 32'(s_fault), 32'(e.fault));
         end
      end
      @(posedge i_Clock);
      if (i_IMemGrant) begin
         h.addr  = s_addr;
         h.epoch = epoch;
         h.err   = (s_addr == err_addr);
         h.rdy   = cyc + 1;
         memq.push_back(h);
         glog.push_back(s_addr);
         exp_req_pc = exp_req_pc + 32'd4;
      end
      if (rv) begin
         h = memq.pop_front();
         if (h.epoch == epoch && !redir) begin
            e.pc    = h.addr;
            e.word  = h.err ? NOP : mem_word(h.addr);
            e.fault = h.err;
            expq.push_back(e);
            if (h.err) begin
               err_seen = 1;
               err_pc   = h.addr;
            end
         end
      end
      if (redir) begin
         epoch++;
         expq.delete();
         exp_req_pc = tgt;
         err_seen   = 0;
         mis_halt   = (tgt[1:0] != 2'b00);
         if (mis_halt) begin
            e.pc    = tgt;
            e.word  = NOP;
            e.fault = 1'b1;
            expq.push_back(e);
         end
      end
      req_pend  = s_req && !i_IMemGrant && !redir;
      pend_addr = s_addr;
      cyc++;
      @(negedge i_Clock);
   endtask

   // Asynchronous reset mid-cycle; in-flight memory traffic is abandoned
   task automatic do_reset();
      #2;
      i_Reset_n   = 1'b0;
      i_Redirect  = 1'b0;
      i_IMemGrant = 1'b0;
      i_IMemValid = 1'b1;
      i_IMemError = 1'b1;
      #1;
      check_eq("rst_req", 32'(o_IMemReq), 0);
      check_eq("rst_valid", 32'(o_Valid), 0);
      check_eq("rst_pc", o_PC, 0);
      check_eq("rst_word", o_InstructionWord, 0);
      check_eq("rst_fault", 32'(o_FetchFault), 0);
      repeat (2) @(negedge i_Clock);
      check_eq("rst_req_held", 32'(o_IMemReq), 0);
      check_eq("rst_valid_held", 32'(o_Valid), 0);
      memq.delete();
      expq.delete();
      glog.delete();
      epoch++;
      exp_req_pc = RV;
      err_seen   = 0;
      mis_halt   = 0;
      req_pend   = 0;
      stray      = 1;
      i_Reset_n  = 1'b1;
   endtask

   task automatic find_pop(input string tag, input logic [31:0] want_pc);
      bit found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(0, '0, 0);
         if (s_valid) begin
            found = 1;
            check_eq(tag, s_pc, want_pc);
         end
      end
      check_eq({tag, "_timeout"}, 32'(found), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] tgt;
      bit          found;
      int          r;

      // Reset release with an always-granting one-cycle memory
      grant_pct = 100; resp_pct = 100; stall_pct = 0;
      do_reset();
      step(0, '0, 0);
      check_eq("first_req", 32'(s_req), 1);
      check_eq("first_addr", s_addr, RV);
      check_eq("first_valid_c0", 32'(s_valid), 0);
      step(0, '0, 0);
      check_eq("first_valid_c1", 32'(s_valid), 0);
      step(0, '0, 0);
      check_eq("first_valid_c2", 32'(s_valid), 1);
      check_eq("first_pc_c2", s_pc, RV);
      repeat (4) step(0, '0, 0);
      check_eq("issue_0", glog[0], 32'h0);
      check_eq("issue_1", glog[1], 32'h4);
      check_eq("issue_2", glog[2], 32'h8);

      // Decode stalled for several cycles: buffer fills with 0 and 4
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(0, '0, 1);
         if (k >= 2) check_eq("stall_req_low", 32'(s_req), 0);
      end
      check_eq("stall_valid", 32'(s_valid), 1);
      check_eq("stall_head_pc", s_pc, 32'h0);
      step(0, '0, 0);
      check_eq("unstall_pop0", s_pc, 32'h0);
      step(0, '0, 0);
      check_eq("unstall_pop1", s_pc, 32'h4);
      repeat (6) step(0, '0, 0);

      // Redirect with two requests still outstanding
      do_reset();
      resp_pct = 0;
      repeat (2) step(0, '0, 0);
      step(0, '0, 0);
      check_eq("two_outstanding_req_low", 32'(s_req), 0);
      resp_pct = 100;
      step(1, 32'h0000_0100, 0);
      find_pop("redirect_first_pc", 32'h0000_0100);
      repeat (4) step(0, '0, 0);

      // Misaligned redirect target
      step(1, 32'h0000_0102, 0);
      step(0, '0, 0);
      check_eq("misaligned_valid", 32'(s_valid), 1);
      check_eq("misaligned_pc", s_pc, 32'h0000_0102);
      check_eq("misaligned_word", s_word, NOP);
      check_eq("misaligned_fault", 32'(s_fault), 1);
      for (int k = 0; k < 5; k++) begin
         step(0, '0, 0);
         check_eq("misaligned_no_req", 32'(s_req), 0);
      end

      // Bus error on PC 8 halts fetch until a redirect
      err_addr = 32'h0000_0008;
      step(1, 32'h0, 0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(0, '0, 0);
         if (s_valid && s_pc == 32'h8) begin
            found = 1;
            check_eq("buserr_fault", 32'(s_fault), 1);
            check_eq("buserr_word", s_word, NOP);
         end
      end
      check_eq("buserr_seen", 32'(found), 1);
      repeat (2) step(0, '0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, '0, 0);
         check_eq("buserr_halted", 32'(s_req), 0);
      end
      err_addr = NO_ERR;
      step(1, 32'h0, 0);
      find_pop("buserr_resume_pc", 32'h0);
      repeat (4) step(0, '0, 0);

      // PC wraparound at the top of the address space
      glog.delete();
      step(1, 32'hFFFF_FFF8, 0);
      repeat (10) step(0, '0, 0);
      found = 0;
      for (int i = 0; i + 1 < glog.size(); i++) begin
         if (!found && glog[i] == 32'hFFFF_FFFC) begin
            found = 1;
            check_eq("wrap_next_addr", glog[i+1], 32'h0);
         end
      end
      check_eq("wrap_seen", 32'(found), 1);

      // Reset in the middle of traffic; a stray response must be ignored
      grant_pct = 70; resp_pct = 50;
      repeat (20) step(0, '0, 0);
      do_reset();
      step(0, '0, 0);
      check_eq("midrst_req", 32'(s_req), 1);
      check_eq("midrst_addr", s_addr, RV);
      repeat (30) step(0, '0, 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) begin
            grant_pct = 30 + $urandom_range(70);
            resp_pct  = 30 + $urandom_range(70);
            stall_pct = $urandom_range(50);
         end
         if (c % 1500 == 1499) do_reset();
         if ($urandom_range(99) < 2) err_addr = exp_req_pc + 32'(4 * $urandom_range(3));
         else if ($urandom_range(99) < 3) err_addr = NO_ERR;
         tgt = $urandom & 32'h0000_0FFC;
         r = $urandom_range(9);
         if (r == 0) tgt[1:0] = 2'($urandom_range(3, 1));
         else if (r == 1) tgt = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
         step(($urandom_range(99) < 3) || ((mis_halt || err_seen) && $urandom_range(99) < 15),
              tgt, $urandom_range(99) < stall_pct);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
